// File: rtl/csa_accum_ctrl.sv
// Multi-operand accumulator sequencer: one 3:2 carry-save stage per accepted operand,
// a single carry-propagate add to resolve the total, and a valid/ready result port.
module csa_accum_ctrl #(
    parameter int unsigned DATA_W  = 9,
    parameter int unsigned ACC_W   = 12,
    parameter int unsigned MAX_OPS = 15,
    parameter int unsigned CNT_W   = $clog2(MAX_OPS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_ops,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [ACC_W-1:0]  out_data,
    input  logic              out_ready,
    output logic              busy
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACCUM   = 2'd1;
    localparam logic [1:0] RESOLVE = 2'd2;
    localparam logic [1:0] OUTPUT  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [ACC_W-1:0] carry_q, carry_d;
    logic [ACC_W-1:0] out_q, out_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] ops_clamped;
    logic [ACC_W-1:0] x, s, m;

    // Compare in 32 bits so the clamp stays meaningful for any CNT_W/MAX_OPS pairing.
    assign ops_clamped = (32'(num_ops) > MAX_OPS) ? CNT_W'(MAX_OPS) : num_ops;

    assign x = ACC_W'(in_data);
    assign s = sum_q ^ carry_q ^ x;
    assign m = (sum_q & carry_q) | (sum_q & x) | (carry_q & x);

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        rem_d   = rem_q;
        out_d   = out_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sum_d   = '0;
                    carry_d = '0;
                    rem_d   = ops_clamped;
                    state_d = (ops_clamped == '0) ? RESOLVE : ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    sum_d   = s;
                    // Majority bits carry into the next weight; the MSB carry wraps away.
                    carry_d = {m[ACC_W-2:0], 1'b0};
                    rem_d   = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = RESOLVE;
                    end
                end
            end
            RESOLVE: begin
                out_d   = sum_q + carry_q;
                state_d = OUTPUT;
            end
            OUTPUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sum_q   <= '0;
            carry_q <= '0;
            rem_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            rem_q   <= rem_d;
            out_q   <= out_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == OUTPUT);
    assign busy      = (state_q != IDLE);
    assign out_data  = out_q;

endmodule
